// File: rtl/wb2axil_pkg.sv
// wb2axil_pkg: bridge FSM states, AXI response codes and response classification.
package wb2axil_pkg;
   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;
   localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
   function automatic logic is_error(input logic [1:0] resp);
      return resp == SLVERR || resp == DECERR;
   endfunction
endpackage

// File: rtl/wb2axil_timeout.sv
// wb2axil_timeout: response-wait counter; expired marks the last allowed cycle, TIMEOUT_CYC=0 disables it.
module wb2axil_timeout #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expired
);
   localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (run && !expired) cnt <= cnt + 1'b1;
   assign expired = (TIMEOUT_CYC != 0) && run && cnt == LAST;
endmodule

// File: rtl/wb2axil_bridge.sv
// wb2axil_bridge: Wishbone classic slave to AXI4-Lite master, one outstanding transaction.
module wb2axil_bridge import wb2axil_pkg::*; #(
   parameter int         ADDR_W      = 32,
   parameter int         DATA_W      = 32,
   parameter int         TIMEOUT_CYC = 256,
   parameter logic [2:0] AXI_PROT    = 3'b000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [ADDR_W-1:0]   wb_adr_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic [DATA_W/8-1:0] wb_sel_i,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [2:0]          awprot,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   output logic [2:0]          arprot,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp
);
   state_t state, state_n;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;
   logic [DATA_W/8-1:0] sel_q;
   logic aw_done, w_done, err_q, run, expired;
   wire aw_hs = awvalid && awready;
   wire w_hs  = wvalid && wready;
   assign run      = state == WRESP || state == RDATA;
   assign awvalid  = state == WADDR && !aw_done;
   assign wvalid   = state == WADDR && !w_done;
   assign arvalid  = state == RADDR;
   assign bready   = state == WRESP || state == IDLE;
   assign rready   = state == RDATA || state == IDLE;
   assign wb_ack_o = state == RESP && !err_q;
   assign wb_err_o = state == RESP && err_q;
   assign awaddr   = adr_q;
   assign araddr   = adr_q;
   assign wdata    = dat_q;
   assign wstrb    = sel_q;
   assign awprot   = AXI_PROT;
   assign arprot   = AXI_PROT;
   wb2axil_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk(clk), .rst_n(rst_n), .run(run), .clear(!run), .expired(expired)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   // Address and write channels may complete in either order or together.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (wb_cyc_i && wb_stb_i) state_n = wb_we_i ? WADDR : RADDR;
         WADDR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WRESP;
         WRESP:   if (bvalid || expired) state_n = RESP;
         RADDR:   if (arready) state_n = RDATA;
         RDATA:   if (rvalid || expired) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         err_q    <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         if (state == IDLE && wb_cyc_i && wb_stb_i) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
         end
         aw_done <= state == WADDR && (aw_done || aw_hs);
         w_done  <= state == WADDR && (w_done || w_hs);
         if (state == WRESP && bvalid) err_q <= is_error(bresp);
         else if (state == RDATA && rvalid) err_q <= is_error(rresp);
         else if (expired) err_q <= 1'b1;
         if (state == RDATA && rvalid) wb_dat_o <= rdata;
      end
endmodule

// File: tb/tb_wb2axil_bridge.sv
// tb_wb2axil_bridge: scoreboard bench; expected Wishbone responses queued at request time, popped on ack/err.
module tb_wb2axil_bridge;
   import wb2axil_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   logic wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
   logic [3:0] wb_sel_i = '0;
   logic wb_ack_o, wb_err_o;
   logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
   logic arvalid, arready = 0, rvalid = 0, rready;
   logic [31:0] awaddr, wdata, araddr, rdata = '0;
   logic [3:0] wstrb;
   logic [2:0] awprot, arprot;
   logic [1:0] bresp = '0, rresp = '0;
   typedef struct {logic err; logic cd; logic [31:0] d;} exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int total = 0, bad = 0, cyc = 0;
   int lat, aw_hi, w_hi, wresp_at, resp_at;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   wb2axil_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16), .AXI_PROT(3'b000)) dut (
      .clk(clk), .rst_n(rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .awvalid(awvalid), .awready(awready),
      .awaddr(awaddr), .awprot(awprot), .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .wstrb(wstrb), .bvalid(bvalid), .bready(bready), .bresp(bresp), .arvalid(arvalid),
      .arready(arready), .araddr(araddr), .arprot(arprot), .rvalid(rvalid), .rready(rready),
      .rdata(rdata), .rresp(rresp)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk)
      if (rst_n && (wb_ack_o || wb_err_o)) begin
         if (sb.size() == 0) chk("spurious_resp", {wb_ack_o, wb_err_o}, 0);
         else begin
            mon_e = sb.pop_front();
            chk("ack", wb_ack_o, !mon_e.err);
            chk("err", wb_err_o, mon_e.err);
            if (mon_e.cd) chk("rdat", wb_dat_o, mon_e.d);
         end
      end
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic exp_err, input logic cd,
                          input logic [31:0] exp_d, input bit drop, output int l);
      int n;
      logic got;
      sb.push_back('{exp_err, cd, exp_d});
      @(posedge clk); #1;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      @(posedge clk); #1;
      n = cyc;
      if (drop) begin wb_cyc_i = 0; wb_stb_i = 0; end
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = wb_ack_o || wb_err_o;
      end
      chk("resp_seen", got, 1);
      l = cyc + 1 - n;
      resp_at = cyc;
      wb_cyc_i = 0; wb_stb_i = 0;
   endtask
   task automatic slave_w(input int aw_lat, input int w_lat, input int b_lat, input logic [1:0] resp,
                          input bit give_b, input logic [31:0] ea, input logic [31:0] ed,
                          input logic [3:0] es, output int ah, output int wh);
      ah = 0; wh = 0;
      for (int i = 0; i < 20 && !awvalid; i++) @(negedge clk);
      chk("awvalid", awvalid, 1);
      chk("awaddr", awaddr, ea);
      chk("wstrb", wstrb, es);
      for (int t = 0; t < 40 && (awvalid || wvalid); t++) begin
         ah += int'(awvalid); wh += int'(wvalid);
         if (wvalid) chk("wdata", wdata, ed);
         awready = (t >= aw_lat); wready = (t >= w_lat);
         @(negedge clk);
      end
      awready = 0; wready = 0;
      wresp_at = cyc;
      repeat (b_lat) @(negedge clk);
      if (give_b) begin
         bvalid = 1; bresp = resp;
         @(negedge clk);
         bvalid = 0; bresp = OKAY;
      end
   endtask
   task automatic slave_r(input int ar_lat, input int r_lat, input logic [31:0] d,
                          input logic [1:0] resp, input logic [31:0] ea);
      for (int i = 0; i < 20 && !arvalid; i++) @(negedge clk);
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, ea);
      for (int t = 0; t < 40 && arvalid; t++) begin
         arready = (t >= ar_lat);
         @(negedge clk);
      end
      arready = 0;
      repeat (r_lat) @(negedge clk);
      rvalid = 1; rdata = d; rresp = resp;
      @(negedge clk);
      rvalid = 0; rdata = '0; rresp = OKAY;
   endtask
   task automatic chk_reset_outs(input string tag);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_ack_err"}, {wb_ack_o, wb_err_o}, 0);
      chk({tag, "_dat"}, wb_dat_o, 0);
      chk({tag, "_readies"}, {bready, rready}, 2'b11);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      #12;
      chk_reset_outs("rst");
      chk("prot", {awprot, arprot}, 0);
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      // single-cycle write, minimum latency
      fork
         wb_xfer(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, lat);
         slave_w(0, 0, 0, OKAY, 1, 32'h1000, 32'hDEADBEEF, 4'hF, aw_hi, w_hi);
      join
      chk("wr_lat", lat, 3);
      // delayed read with slave error, data still captured
      fork
         wb_xfer(0, 32'h2004, 0, 4'hF, 1, 1, 32'h12345678, 0, lat);
         slave_r(0, 5, 32'h12345678, SLVERR, 32'h2004);
      join
      // wready three cycles behind awready
      fork
         wb_xfer(1, 32'h3008, 32'hCAFEF00D, 4'h3, 0, 0, 0, 0, lat);
         slave_w(0, 3, 0, EXOKAY, 1, 32'h3008, 32'hCAFEF00D, 4'h3, aw_hi, w_hi);
      join
      chk("aw_cycles", aw_hi, 1);
      chk("w_cycles", w_hi, 4);
      // master abandons cyc early; DECERR still reported
      fork
         wb_xfer(1, 32'h300C, 32'h11223344, 4'hC, 1, 0, 0, 1, lat);
         slave_w(2, 1, 2, DECERR, 1, 32'h300C, 32'h11223344, 4'hC, aw_hi, w_hi);
      join
      chk("dat_hold", wb_dat_o, 32'h12345678);
      chk("aw_cycles2", aw_hi, 3);
      // minimum-latency read with EXOKAY
      fork
         wb_xfer(0, 32'h5000, 0, 4'hF, 0, 1, 32'hA5A50F0F, 0, lat);
         slave_r(0, 0, 32'hA5A50F0F, EXOKAY, 32'h5000);
      join
      chk("rd_lat", lat, 3);
      // write response never arrives
      fork
         wb_xfer(1, 32'h4000, 32'h1, 4'h1, 1, 0, 0, 0, lat);
         slave_w(0, 0, 0, OKAY, 0, 32'h4000, 32'h1, 4'h1, aw_hi, w_hi);
      join
      chk("tmo_cycles", resp_at - wresp_at, 16);
      @(negedge clk);
      bvalid = 1; bresp = OKAY;
      @(negedge clk);
      bvalid = 0;
      repeat (3) begin
         chk("late_b", {wb_ack_o, wb_err_o}, 0);
         @(negedge clk);
      end
      // reset while waiting in RDATA
      @(posedge clk); #1;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h6000;
      for (int i = 0; i < 20 && !arvalid; i++) @(negedge clk);
      chk("rst_arvalid_pre", arvalid, 1);
      arready = 1;
      @(negedge clk);
      arready = 0;
      @(negedge clk);
      chk("rdata_bready", bready, 0);
      #2 rst_n = 0;
      #1 chk_reset_outs("async");
      wb_cyc_i = 0; wb_stb_i = 0;
      @(negedge clk); rst_n = 1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst", {wb_ack_o, wb_err_o}, 0);
      end
      fork
         wb_xfer(1, 32'h7000, 32'h55AA55AA, 4'h5, 0, 0, 0, 0, lat);
         slave_w(1, 0, 1, OKAY, 1, 32'h7000, 32'h55AA55AA, 4'h5, aw_hi, w_hi);
      join
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb2axil_bridge.md
WB2AXIL_BRIDGE -- requirements
Module: wb2axil_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: address width on both sides.
REQ-002 Parameter DATA_W, default 32: data width; legal values 32 or 64 only; SEL_W = DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, default 256: response-wait limit in cycles; 0 disables the timeout.
REQ-004 Parameter AXI_PROT, default 3'b000: constant driven on awprot/arprot.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic slave cycle, strobe and write-enable.
REQ-008 wb_adr_i  in  ADDR_W; wb_dat_i  in  DATA_W; wb_sel_i  in  SEL_W  Wishbone request fields.
REQ-009 wb_dat_o  out  DATA_W; wb_ack_o  out  1; wb_err_o  out  1  Wishbone response.
REQ-010 awvalid out 1, awready in 1, awaddr out ADDR_W, awprot out 3  AXI4-Lite write address.
REQ-011 wvalid out 1, wready in 1, wdata out DATA_W, wstrb out SEL_W  AXI4-Lite write data.
REQ-012 bvalid in 1, bready out 1, bresp in 2  AXI4-Lite write response.
REQ-013 arvalid out 1, arready in 1, araddr out ADDR_W, arprot out 3  AXI4-Lite read address.
REQ-014 rvalid in 1, rready out 1, rdata in DATA_W, rresp in 2  AXI4-Lite read data.

Function
REQ-015 The FSM SHALL have states IDLE, WADDR, WRESP, RADDR, RDATA and RESP.
REQ-016 In IDLE, wb_cyc_i & wb_stb_i SHALL register adr/dat/sel/we and move to WADDR (we=1) or RADDR (we=0) on the next edge.
REQ-017 In WADDR, awvalid and wvalid SHALL both assert; each SHALL deassert independently after its own handshake; the FSM moves to WRESP once both have completed, including completion in the same cycle.
REQ-018 In RADDR, arvalid SHALL assert until arready; the FSM then moves to RDATA.
REQ-019 bready SHALL be 1 in WRESP and IDLE; rready SHALL be 1 in RDATA and IDLE; a response accepted in IDLE SHALL be discarded with no Wishbone effect.
REQ-020 In RDATA, wb_dat_o SHALL capture rdata on rvalid & rready and hold until the next read capture.
REQ-021 A response with resp==2'b00 or 2'b01 SHALL yield wb_ack_o; resp 2'b10 or 2'b11 SHALL yield wb_err_o.
REQ-022 In RESP, exactly one of wb_ack_o and wb_err_o SHALL pulse for one cycle; the FSM then returns to IDLE.
REQ-023 Minimum latency, with ready and response signals immediate: stb sampled at edge N, ack/err high in cycle N+3.
REQ-024 A timeout counter SHALL run only in WRESP and RDATA, clearing on state entry; when it reaches TIMEOUT_CYC-1, the FSM enters RESP with wb_err_o.
REQ-025 Address-phase valids SHALL never drop before their handshake; no timeout applies in WADDR or RADDR.
REQ-026 Deassertion of wb_cyc_i mid-transaction SHALL NOT abort the AXI side; the RESP pulse is still issued.
REQ-027 awaddr/araddr/wdata/wstrb SHALL come from registered copies, stable while their valid is high.

Reset
REQ-028 While rst_n=0: state IDLE, all valids 0, ack/err 0, wb_dat_o 0, counter 0, bready and rready 1.
REQ-029 Reset mid-transaction SHALL abandon the transaction immediately, with no ack/err after release.

Structure
REQ-030 Package wb2axil_pkg SHALL hold the state enum, the AXI resp localparams (OKAY, EXOKAY, SLVERR, DECERR) and the is_error function.
REQ-031 The timeout counter SHALL be sub-module wb2axil_timeout, with parameter TIMEOUT_CYC and ports clk, rst_n, run, clear, expired.

Verification
REQ-032 Write 0x1000 with data 0xDEADBEEF, sel 0xF, awready=wready=1, bvalid next cycle with OKAY -> awaddr 0x1000, wstrb 0xF, ack at N+3.
REQ-033 Read 0x2004 with rvalid delayed 5 cycles, rdata 0x12345678, rresp SLVERR -> wb_err_o pulse, wb_dat_o=0x12345678.
REQ-034 wready arrives 3 cycles after awready -> awvalid drops after 1 cycle, wvalid after 4, single WRESP entry.
REQ-035 TIMEOUT_CYC=16 and bvalid never asserted -> wb_err_o exactly 16 cycles after WRESP entry; a late bvalid in IDLE is ignored.
REQ-036 rst_n pulled low in RDATA -> all outputs reach their reset values asynchronously, and no ack after release.
